burst_deserializer: RTL and testbench

- Assembles a multi-beat memory burst into one wide line, e.g. 4 x 64-bit beats from physical memory into a 256-bit cache line.
- It is the demultiplexing end of the serializing path that selects beats out of a line one at a time.
- Sits between the memory-side burst interface and the cache line-fill datapath.
- A beat counter steers each incoming word into its slot of the output register.

---
 rtl/burst_deserializer.sv | 105 ++++++++++
 tb/tb_burst_deserializer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/burst_deserializer.sv
// Assembles BEATS incoming words of WIDTH bits into one output line using a
// beat counter and a slot index. Optional macro CRITICAL_FIRST_EN: start at start_offset.
module burst_deserializer #(
    parameter  int WIDTH = 64,
    parameter  int BEATS = 4,
    localparam int IW    = $clog2(BEATS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [IW-1:0]          start_offset,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [WIDTH*BEATS-1:0] out_data,
    input  logic                   out_ready,
    output logic                   busy
);

    // Handshakes: a beat transfers on in_valid & in_ready, a line on
    // out_valid & out_ready; ready/valid come from registered state only.
    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t                 state, state_nxt;
    logic [IW-1:0]          idx;
    logic [IW-1:0]          cnt;
    logic [IW-1:0]          load_idx;
    logic [WIDTH*BEATS-1:0] line;
    logic                   accept;
    logic                   load;

`ifdef CRITICAL_FIRST_EN
    assign load_idx = start_offset;
`else
    logic unused_start_offset;
    assign unused_start_offset = ^start_offset;
    assign load_idx = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = FILL;
                end
            end
            FILL: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                accept   = in_valid;
                if (in_valid && cnt == IW'(BEATS - 1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    if (start) begin
                        load      = 1'b1;
                        state_nxt = FILL;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Slots untouched by the current burst keep their old contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            line <= '0;
            idx  <= '0;
            cnt  <= '0;
        end else if (load) begin
            idx <= load_idx;
            cnt <= '0;
        end else if (accept) begin
            line[idx*WIDTH +: WIDTH] <= in_data;
            idx <= idx + IW'(1);
            cnt <= cnt + IW'(1);
        end
    end

    assign out_data = line;

endmodule

// File: tb/tb_burst_deserializer.sv
// Scoreboard bench for burst_deserializer: bursts push expected lines into a
// queue, a monitor pops and compares on every line handshake.
module tb_burst_deserializer;

    localparam int W = 64;
    localparam int N = 4;
    localparam int L = W * N;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   start_offset = 2'd0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         out_valid;
    logic [L-1:0] out_data;
    logic         out_ready = 1'b0;
    logic         busy;

    logic [L-1:0] exp_q[$];
    int           checks = 0;
    int           errors = 0;

    burst_deserializer #(.WIDTH(W), .BEATS(N)) dut (
        .clk(clk), .rst(rst), .start(start), .start_offset(start_offset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [L-1:0] act, input logic [L-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input logic [1:0] off);
        start = 1'b1;
        start_offset = off;
        tick();
        start = 1'b0;
        start_offset = 2'd0;
    endtask

    task automatic send_beat(input logic [W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_data  = 64'hDEAD_BEEF_0000_0000 | W'($urandom_range(0, 255));
    endtask

    task automatic accept_line();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    function automatic logic [L-1:0] mk(input logic [W-1:0] s0, s1, s2, s3);
        return {s3, s2, s1, s0};
    endfunction

    task automatic monitor_loop();
        logic [L-1:0] exp;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_line", out_data, '0);
                    if (out_data === '0) begin
                        errors++;
                        $display("FAIL unexpected_line: got a line with empty queue, required none");
                    end
                end else begin
                    exp = exp_q.pop_front();
                    check("line_data", out_data, exp);
                end
            end
        end
    endtask

    initial begin
        fork
            monitor_loop();
        join_none

        // Reset state
        tick();
        tick();
        check("rst_in_ready", L'(in_ready), '0);
        check("rst_out_valid", L'(out_valid), '0);
        check("rst_busy", L'(busy), '0);
        check("rst_out_data", out_data, '0);
        rst = 1'b0;
        tick();

        // Basic fill
        start_burst(2'd0);
        check("fill_busy", L'(busy), L'(1));
        exp_q.push_back(mk(64'hA0, 64'hA1, 64'hA2, 64'hA3));
        send_beat(64'hA0);
        send_beat(64'hA1);
        send_beat(64'hA2);
        check("basic_not_done_early", L'(out_valid), '0);
        send_beat(64'hA3);
        check("basic_out_valid", L'(out_valid), L'(1));
        check("basic_in_ready_done", L'(in_ready), '0);
        check("basic_busy_done", L'(busy), L'(1));
        accept_line();
        check("basic_idle_busy", L'(busy), '0);
        check("basic_idle_out_valid", L'(out_valid), '0);

        // Stall between beat 1 and beat 2
        start_burst(2'd0);
        exp_q.push_back(mk(64'hA0, 64'hA1, 64'hA2, 64'hA3));
        send_beat(64'hA0);
        send_beat(64'hA1);
        for (int i = 0; i < 3; i++) begin
            in_data = 64'h5555_0000_0000_0000 + W'(i);
            tick();
        end
        check("stall_in_ready", L'(in_ready), L'(1));
        check("stall_out_valid", L'(out_valid), '0);
        send_beat(64'hA2);
        send_beat(64'hA3);
        check("stall_out_valid_late", L'(out_valid), L'(1));
        accept_line();

        // Backpressure with start held, then back-to-back
        start_burst(2'd0);
        exp_q.push_back(mk(64'hE0, 64'hE1, 64'hE2, 64'hE3));
        send_beat(64'hE0);
        send_beat(64'hE1);
        send_beat(64'hE2);
        send_beat(64'hE3);
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_out_valid", L'(out_valid), L'(1));
            check("bp_out_data", out_data, mk(64'hE0, 64'hE1, 64'hE2, 64'hE3));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        start = 1'b0;
        check("b2b_busy", L'(busy), L'(1));
        check("b2b_in_ready", L'(in_ready), L'(1));
        check("b2b_out_valid", L'(out_valid), '0);
        exp_q.push_back(mk(64'hB0, 64'hB1, 64'hB2, 64'hB3));
        send_beat(64'hB0);
        send_beat(64'hB1);
        send_beat(64'hB2);
        send_beat(64'hB3);
        accept_line();

        // Reset mid-burst
        start_burst(2'd0);
        send_beat(64'hF0);
        send_beat(64'hF1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_out_valid", L'(out_valid), '0);
        check("midrst_out_data", out_data, '0);
        check("midrst_busy", L'(busy), '0);
        check("midrst_in_ready", L'(in_ready), '0);
        start_burst(2'd0);
        exp_q.push_back(mk(64'hC0, 64'hC1, 64'hC2, 64'hC3));
        send_beat(64'hC0);
        send_beat(64'hC1);
        send_beat(64'hC2);
        send_beat(64'hC3);
        accept_line();

        // Critical-first offset
        start_burst(2'd2);
`ifdef CRITICAL_FIRST_EN
        exp_q.push_back(mk(64'hD2, 64'hD3, 64'hD0, 64'hD1));
`else
        exp_q.push_back(mk(64'hD0, 64'hD1, 64'hD2, 64'hD3));
`endif
        send_beat(64'hD0);
        send_beat(64'hD1);
        send_beat(64'hD2);
        send_beat(64'hD3);
        accept_line();

        // start asserted during FILL has no effect
        start_burst(2'd0);
        exp_q.push_back(mk(64'h70, 64'h71, 64'h72, 64'h73));
        send_beat(64'h70);
        send_beat(64'h71);
        start = 1'b1;
        start_offset = 2'd1;
        send_beat(64'h72);
        start = 1'b0;
        start_offset = 2'd0;
        check("fillstart_not_done", L'(out_valid), '0);
        send_beat(64'h73);
        check("fillstart_done", L'(out_valid), L'(1));
        accept_line();

        tick();
        check("queue_drained", L'(exp_q.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
